// File: rtl/data_mem_pipe.sv
// data_mem_pipe
//   Flop-based data memory behind the LSU with split request/response
//   channels, a fixed access latency and several requests in flight.
//   Requests commit writes and sample read data at the accept edge.
//   Results then travel through a LATENCY-deep shift register into an
//   in-order response queue. A credit counter keeps the number of
//   accepted-but-unconsumed responses at or below MAX_OUTST, so neither
//   the pipe nor the queue can overflow.
// Ports
//   i_clk, i_rst_n            clock (rising edge), async active-low reset
//   i_VALID/o_READY           request handshake
//   i_ADDR, i_WDATA, i_BMASK  byte address, write data, byte-lane enables
//   i_WREN                    1 = write, 0 = read
//   o_RVALID/i_RREADY         response handshake
//   o_RDATA, o_RWR, o_RERR    read data (0 for writes/errors), write flag,
//                             out-of-range flag
module data_mem_pipe #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 18,
  parameter int N_WORDS   = 4096,
  parameter int LATENCY   = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_VALID,
  output logic                  o_READY,
  input  logic [ADDR_W-1:0]     i_ADDR,
  input  logic [DATA_W-1:0]     i_WDATA,
  input  logic [DATA_W/8-1:0]   i_BMASK,
  input  logic                  i_WREN,
  output logic                  o_RVALID,
  input  logic                  i_RREADY,
  output logic [DATA_W-1:0]     o_RDATA,
  output logic                  o_RWR,
  output logic                  o_RERR
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF   = (NB > 1) ? $clog2(NB) : 0;
  localparam int IDX_W = ADDR_W - OFF;
  localparam int MW    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int PD    = (LATENCY > 1) ? LATENCY - 1 : 1;
  localparam int PW    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW    = $clog2(MAX_OUTST + 1);

  typedef struct packed {
    logic              err;
    logic              wr;
    logic [DATA_W-1:0] rdata;
  } entry_t;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [DATA_W-1:0] mem_q [N_WORDS];

  logic [IDX_W-1:0] idx;
  logic [MW-1:0]    mem_idx;
  logic             in_range;
  logic             accept;
  logic             pop;
  logic             unused_addr;
  entry_t           acc_ent;

  logic [PD-1:0]    pipe_vld_q;
  entry_t           pipe_ent_q [PD];
  logic             push_vld;
  entry_t           push_ent;

  entry_t           q_mem_q [MAX_OUTST];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d, credit_q, credit_d;
  entry_t           head;

  assign idx         = i_ADDR[ADDR_W-1:OFF];
  assign mem_idx     = idx[MW-1:0];
  assign in_range    = 32'(idx) < 32'(N_WORDS);
  assign unused_addr = ^i_ADDR;

  assign o_RVALID = (count_q != '0);
  assign pop      = o_RVALID & i_RREADY;
  // A pop in this cycle frees a slot at the same edge, so a new request
  // may be taken even with zero credit; this keeps one request per cycle.
  assign o_READY  = i_rst_n & ((credit_q != '0) | pop);
  assign accept   = i_VALID & o_READY;

  // Accept edge: read samples the array before this edge's write lands
  always_comb begin
    acc_ent.err   = !in_range;
    acc_ent.wr    = i_WREN;
    acc_ent.rdata = (in_range && !i_WREN) ? mem_q[mem_idx] : '0;
  end

  always_ff @(posedge i_clk) begin
    if (accept && i_WREN && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (i_BMASK[i]) mem_q[mem_idx][8*i +: 8] <= i_WDATA[8*i +: 8];
      end
    end
  end

  // Latency pipe: stages 1..LATENCY-1; the queue push is the last stage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q[0] <= accept;
      for (int i = 1; i < PD; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
    end
  end

  always_ff @(posedge i_clk) begin
    pipe_ent_q[0] <= acc_ent;
    for (int i = 1; i < PD; i++) pipe_ent_q[i] <= pipe_ent_q[i-1];
  end

  generate
    if (LATENCY == 1) begin : g_lat1
      assign push_vld = accept;
      assign push_ent = acc_ent;
    end else begin : g_latn
      assign push_vld = pipe_vld_q[PD-1];
      assign push_ent = pipe_ent_q[PD-1];
    end
  endgenerate

  // Response queue and credit bookkeeping
  always_comb begin
    count_d  = count_q;
    credit_d = credit_q;
    wptr_d   = push_vld ? ptr_inc(wptr_q) : wptr_q;
    rptr_d   = pop ? ptr_inc(rptr_q) : rptr_q;
    case ({push_vld, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    case ({accept, pop})
      2'b10:   credit_d = credit_q - CW'(1);
      2'b01:   credit_d = credit_q + CW'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q  <= '0;
      credit_q <= CW'(MAX_OUTST);
      wptr_q   <= '0;
      rptr_q   <= '0;
    end else begin
      count_q  <= count_d;
      credit_q <= credit_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_vld) q_mem_q[wptr_q] <= push_ent;
  end

  // Response outputs are forced to zero while the queue is empty
  assign head    = q_mem_q[rptr_q];
  assign o_RDATA = o_RVALID ? head.rdata : '0;
  assign o_RWR   = o_RVALID & head.wr;
  assign o_RERR  = o_RVALID & head.err;

endmodule
